fractal_stream_engine: RTL and testbench
========================================

Name: fractal_stream_engine

Overview:
Parametrised successor to the fixed-resolution fractal pixel generator. It computes one escape-time fractal pixel at a time in fixed point, in either Mandelbrot or Julia mode. It emits 24-bit RGB pixels on an AXI4-Stream style master with start-of-frame and end-of-line sideband. It sits between the AXI-Lite register file, which drives its config ports, and the pixel packer/VDMA path.

Parameters:
W, 32, signed fixed-point word width of z, c, offsets and step
FRAC, 8, fractional bits (1.0 = 1<<FRAC)
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
ITER_W, 8, width of the iteration counter and of max_iter
COLOR_G, 3, green multiplier applied to the iteration count
COLOR_B, 5, blue multiplier applied to the iteration count

Ports:
aclk  in  1  single clock
aresetn  in  1  asynchronous active-low reset
run  in  1  level; while high, frames are generated back to back
mode  in  1  0 = Mandelbrot (c from pixel, z0 = 0), 1 = Julia (z0 from pixel, c = julia_c)
max_iter  in  ITER_W  iteration limit, 1..2^ITER_W-1
julia_c_re  in  W  Julia constant, real part
julia_c_im  in  W  Julia constant, imaginary part
off_re  in  W  plane coordinate of pixel x=0
off_im  in  W  plane coordinate of pixel y=0
step_re  in  W  plane increment per x
step_im  in  W  plane increment per y
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted
m_tdata  out  24  {r,g,b}
m_tvalid  out  1  pixel valid
m_tready  in  1  sink ready
m_tuser  out  1  start of frame; high with pixel (0,0)
m_tlast  out  1  end of line; high with x = X_SIZE-1

Behaviour:
- Reset (async, aresetn=0): state=IDLE; x=y=0; all outputs 0.
- Config latching: all config inputs are captured into shadow registers when a frame starts. They are stable for the whole frame. Input changes mid-frame take effect only at the next frame.
- Coordinates: plane_re = off_re + x*step_re and plane_im = off_im + y*step_im, formed incrementally by adding step each pixel/line. No multiplier is used. Sums wrap modulo 2^W.
- FSM:
  - IDLE: if run, latch config, x=y=0, go INIT.
  - INIT (1 cycle): iter=0. Mandelbrot: c=plane, z=0. Julia: c=julia_c, z=plane. Go ITER.
  - ITER (1 iteration/cycle):
    - zr2 = (zr*zr)>>>FRAC and zi2 = (zi*zi)>>>FRAC. Products are full 2W, arithmetic shift, truncated to W.
    - If zr2+zi2 > 4<<FRAC (signed compare), or iter==max_iter, go EMIT.
    - Otherwise update zr = zr2-zi2+cr and zi = ((2*zr*zi)>>>FRAC)+ci, set iter=iter+1, and stay in ITER.
  - EMIT: m_tvalid=1, holding m_tdata, m_tuser and m_tlast stable until m_tready. On acceptance, advance x, wrapping at X_SIZE-1 and incrementing y.
    - Last pixel accepted: pulse frame_done. If run, latch config and go INIT with x=y=0; otherwise go IDLE.
    - Any other pixel: go INIT.
- Colour: if iter==max_iter, tdata=0 (interior). Otherwise r=iter mod 256, g=(iter*COLOR_G) mod 256, b=(iter*COLOR_B) mod 256.
- Latency: a pixel with n iterations is presented 2+n cycles after the previous acceptance (INIT + n ITER + EMIT entry). Back-pressure stalls only in EMIT.
- busy=1 in INIT, ITER and EMIT.
- run deasserted mid-frame: the current frame completes, then the block goes IDLE.
- max_iter=0 is treated as 1.

Optional Feature:
Macro FRACTAL_PERF_CNT_EN.
- Defined: adds output port perf_cycles [31:0]. It counts aclk cycles from frame start to frame_done, saturates at all-ones, and updates on each frame_done.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package fractal_pkg holds:
  - the state enum (IDLE, INIT, ITER, EMIT);
  - the MODE_MANDEL and MODE_JULIA constants;
  - the function fx_mul(a,b), which returns (a*b)>>>FRAC truncated to W.
- One sub-module, fractal_color_map: combinational iteration-to-RGB mapping, parametrised by ITER_W, COLOR_G and COLOR_B.

Test Plan:
- Escape after one iteration: FRAC=8, mode=0, off_re=640, off_im=0, step=0, max_iter=50, m_tready=1. Expect every pixel tdata={8'd1,8'd3,8'd5}, produced 2+1 cycles after the previous acceptance.
- Interior pixel: off=0, step=0, mode=0. Expect every pixel tdata=0 after 50 ITER cycles.
- Sideband: X_SIZE=4, Y_SIZE=2. Expect exactly 8 beats; tuser only on beat 0; tlast on beats 3 and 7; a frame_done pulse on beat 7; the next frame's tuser follows if run=1.
- Back-pressure: m_tready held low for 10 cycles during EMIT. Expect tvalid held high, tdata/tuser/tlast stable, and x not advanced.
- Config isolation and run-off: change off_re mid-frame and drop run. Expect the frame to finish with the old offset, then busy=0 and no further beats; the next run rising edge uses the new offset.
- Async reset mid-ITER: drop aresetn with no clock edge. Expect tvalid, busy and frame_done to be 0 immediately; after release with run=1, the frame restarts at (0,0) with tuser.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared state encoding, mode constants and fixed-point multiply helper
// for the fractal stream engine.
package fractal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam logic MODE_MANDEL = 1'b0;
  localparam logic MODE_JULIA  = 1'b1;

  // Operands arrive sign-extended to 64 bits; the caller truncates the result to its word width.
  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int                 frac);
    logic signed [127:0] p;
    p = 128'(a) * 128'(b);
    return 64'(p >>> frac);
  endfunction

endpackage

// File: rtl/fractal_stream_engine_if.sv
// AXI4-Stream style pixel channel: 24-bit RGB with start-of-frame (tuser)
// and end-of-line (tlast) sideband.
interface fractal_stream_engine_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/fractal_color_map.sv
// Combinational iteration-count to RGB mapping; interior points
// (count reached the limit) are black.
module fractal_color_map #(
  parameter int ITER_W  = 8,
  parameter int COLOR_G = 3,
  parameter int COLOR_B = 5
) (
  input  logic [ITER_W-1:0] iter,
  input  logic [ITER_W-1:0] max_iter,
  output logic [23:0]       rgb
);

  always_comb begin
    rgb = '0;
    if (iter != max_iter) begin
      rgb = {8'(32'(iter)),
             8'(32'(iter) * 32'(COLOR_G)),
             8'(32'(iter) * 32'(COLOR_B))};
    end
  end

endmodule

// File: rtl/fractal_stream_engine.sv
// Escape-time Mandelbrot/Julia pixel generator streaming RGB beats.
// Optional build macro FRACTAL_PERF_CNT_EN adds the perf_cycles frame-length counter.
//
// state | meaning
// IDLE  | waiting for run; config is latched on leaving
// INIT  | load z/c for the current pixel, clear iteration count
// ITER  | one z <- z^2 + c step per cycle until escape or limit
// EMIT  | pixel presented on the stream until accepted
module fractal_stream_engine
  import fractal_pkg::*;
#(
  parameter int W       = 32,
  parameter int FRAC    = 8,
  parameter int X_SIZE  = 640,
  parameter int Y_SIZE  = 480,
  parameter int ITER_W  = 8,
  parameter int COLOR_G = 3,
  parameter int COLOR_B = 5
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                run,
  input  logic                mode,
  input  logic [ITER_W-1:0]   max_iter,
  input  logic signed [W-1:0] julia_c_re,
  input  logic signed [W-1:0] julia_c_im,
  input  logic signed [W-1:0] off_re,
  input  logic signed [W-1:0] off_im,
  input  logic signed [W-1:0] step_re,
  input  logic signed [W-1:0] step_im,
  output logic                busy,
  output logic                frame_done,
  fractal_stream_engine_if.master m
`ifdef FRACTAL_PERF_CNT_EN
  , output logic [31:0]       perf_cycles
`endif
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic signed [W-1:0] THRESH = W'(4 << FRAC);

  state_t state, state_nx;

  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic                mode_s;
  logic [ITER_W-1:0]   max_s, iter;
  logic signed [W-1:0] jc_re_s, jc_im_s, off_re_s, step_re_s, step_im_s;
  logic signed [W-1:0] plane_re, plane_im, zr, zi, cr, ci;
  logic signed [W-1:0] zr2, zi2, mag, zr_nx, zi_nx;
  logic                escaped, x_last, y_last, frame_last, accept, start;
  logic [23:0]         rgb;

  assign zr2     = W'(fx_mul(64'(zr), 64'(zr), FRAC));
  assign zi2     = W'(fx_mul(64'(zi), 64'(zi), FRAC));
  assign mag     = zr2 + zi2;
  assign zr_nx   = zr2 - zi2 + cr;
  assign zi_nx   = W'(fx_mul(64'(zr) <<< 1, 64'(zi), FRAC)) + ci;
  assign escaped = (mag > THRESH) || (iter == max_s);

  assign x_last     = (x == XW'(X_SIZE - 1));
  assign y_last     = (y == YW'(Y_SIZE - 1));
  assign frame_last = x_last && y_last;
  assign accept     = (state == EMIT) && m.tready;
  assign start      = ((state == IDLE) && run) || (accept && frame_last && run);

  fractal_color_map #(
    .ITER_W (ITER_W),
    .COLOR_G(COLOR_G),
    .COLOR_B(COLOR_B)
  ) u_color_map (
    .iter    (iter),
    .max_iter(max_s),
    .rgb     (rgb)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    m.tvalid   = 1'b0;
    m.tdata    = '0;
    m.tuser    = 1'b0;
    m.tlast    = 1'b0;
    unique case (state)
      IDLE: if (run) state_nx = INIT;
      INIT: begin
        busy     = 1'b1;
        state_nx = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (escaped) state_nx = EMIT;
      end
      EMIT: begin
        busy     = 1'b1;
        m.tvalid = 1'b1;
        m.tdata  = rgb;
        m.tuser  = (x == '0) && (y == '0);
        m.tlast  = x_last;
        if (m.tready) begin
          frame_done = frame_last;
          state_nx   = (frame_last && !run) ? IDLE : INIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Plane coordinates track x/y incrementally; a new line reloads the real offset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x         <= '0;
      y         <= '0;
      mode_s    <= MODE_MANDEL;
      max_s     <= '0;
      jc_re_s   <= '0;
      jc_im_s   <= '0;
      off_re_s  <= '0;
      step_re_s <= '0;
      step_im_s <= '0;
      plane_re  <= '0;
      plane_im  <= '0;
      zr        <= '0;
      zi        <= '0;
      cr        <= '0;
      ci        <= '0;
      iter      <= '0;
    end else begin
      if (start) begin
        mode_s    <= mode;
        max_s     <= (max_iter == '0) ? ITER_W'(1) : max_iter;
        jc_re_s   <= julia_c_re;
        jc_im_s   <= julia_c_im;
        off_re_s  <= off_re;
        step_re_s <= step_re;
        step_im_s <= step_im;
        plane_re  <= off_re;
        plane_im  <= off_im;
        x         <= '0;
        y         <= '0;
      end else if (accept) begin
        if (x_last) begin
          x        <= '0;
          y        <= y + YW'(1);
          plane_re <= off_re_s;
          plane_im <= plane_im + step_im_s;
        end else begin
          x        <= x + XW'(1);
          plane_re <= plane_re + step_re_s;
        end
      end

      if (state == INIT) begin
        iter <= '0;
        if (mode_s == MODE_JULIA) begin
          cr <= jc_re_s;
          ci <= jc_im_s;
          zr <= plane_re;
          zi <= plane_im;
        end else begin
          cr <= plane_re;
          ci <= plane_im;
          zr <= '0;
          zi <= '0;
        end
      end else if ((state == ITER) && !escaped) begin
        zr   <= zr_nx;
        zi   <= zi_nx;
        iter <= iter + ITER_W'(1);
      end
    end
  end

`ifdef FRACTAL_PERF_CNT_EN
  logic [31:0] frame_cnt, cnt_inc;

  assign cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + 32'd1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt   <= '0;
      perf_cycles <= '0;
    end else begin
      if (frame_done) perf_cycles <= cnt_inc;
      if (start)      frame_cnt <= '0;
      else if (busy)  frame_cnt <= cnt_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fractal_stream_engine.sv
// Self-checking bench for fractal_stream_engine on a 4x2 frame: directed table,
// back-pressure, back-to-back frames, randomized configs and async reset.
module tb_fractal_stream_engine;

  localparam int XS   = 4;
  localparam int YS   = 2;
  localparam int NPIX = XS * YS;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              run = 1'b0;
  logic              mode = 1'b0;
  logic [7:0]        max_iter = 8'd0;
  logic signed [31:0] julia_c_re = 0, julia_c_im = 0;
  logic signed [31:0] off_re = 0, off_im = 0, step_re = 0, step_im = 0;
  logic              busy, frame_done;

  fractal_stream_engine_if s();

  fractal_stream_engine #(
    .W(32), .FRAC(8), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(8), .COLOR_G(3), .COLOR_B(5)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .run       (run),
    .mode      (mode),
    .max_iter  (max_iter),
    .julia_c_re(julia_c_re),
    .julia_c_im(julia_c_im),
    .off_re    (off_re),
    .off_im    (off_im),
    .step_re   (step_re),
    .step_im   (step_im),
    .busy      (busy),
    .frame_done(frame_done),
    .m         (s)
  );

  typedef struct {
    bit md; int mi; int jre; int jim; int ore; int oim; int sre; int sim;
  } cfg_t;

  typedef struct {
    cfg_t        c;
    logic [23:0] rgb0;
    int          lat0;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc;
  int          lat0;
  logic [23:0] rgb0;
  vec_t        tab [6];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: direct escape-time iteration with wide integer products.
  function automatic void ref_pix(input cfg_t c, input int pre, input int pim,
                                  output int n, output logic [23:0] rgb);
    int zr, zi, cr, ci, zr2, zi2, t, lim;
    lim = (c.mi == 0) ? 1 : c.mi;
    if (c.md) begin cr = c.jre; ci = c.jim; zr = pre; zi = pim; end
    else      begin cr = pre;   ci = pim;   zr = 0;   zi = 0;   end
    n = 0;
    for (int k = 0; k < 300; k++) begin
      zr2 = int'((longint'(zr) * longint'(zr)) >>> 8);
      zi2 = int'((longint'(zi) * longint'(zi)) >>> 8);
      if ((zr2 + zi2) > 1024 || n == lim) break;
      t  = zr2 - zi2 + cr;
      zi = int'((2 * longint'(zr) * longint'(zi)) >>> 8) + ci;
      zr = t;
      n++;
    end
    rgb = (n == lim) ? 24'h0 : {8'(n), 8'(n * 3), 8'(n * 5)};
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.md  = 1'($urandom_range(0, 1));
    c.mi  = int'($urandom_range(0, 30));
    c.jre = int'($urandom_range(0, 768)) - 384;
    c.jim = int'($urandom_range(0, 768)) - 384;
    c.ore = int'($urandom_range(0, 1280)) - 768;
    c.oim = int'($urandom_range(0, 1024)) - 512;
    c.sre = int'($urandom_range(0, 128)) - 64;
    c.sim = int'($urandom_range(0, 128)) - 64;
    return c;
  endfunction

  task automatic apply(input cfg_t c);
    mode       = c.md;
    max_iter   = 8'(c.mi);
    julia_c_re = c.jre;
    julia_c_im = c.jim;
    off_re     = c.ore;
    off_im     = c.oim;
    step_re    = c.sre;
    step_im    = c.sim;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (s.tvalid) begin ok = 1'b1; break; end
    end
  endtask

  // One frame; config inputs are scrambled after beat 0 to prove they were latched.
  task automatic run_frame(input cfg_t c, input int stall_beat, input bit keep_run);
    bit ok;
    int acc, n, px, py;
    logic [23:0] exp_rgb, d;
    logic u, l;
    @(negedge aclk);
    apply(c);
    run = 1'b1;
    s.tready = (stall_beat == 0) ? 1'b0 : 1'b1;
    acc = cyc + 1;
    for (int b = 0; b < NPIX; b++) begin
      px = b % XS;
      py = b / XS;
      ref_pix(c, c.ore + px * c.sre, c.oim + py * c.sim, n, exp_rgb);
      wait_valid(600, ok);
      chk("beat_valid_timeout", 64'(ok), 64'd1);
      if (!ok) return;
      chk("latency", 64'(cyc - acc), 64'(2 + n));
      if (b == 0) begin rgb0 = s.tdata; lat0 = cyc - acc; end
      chk("tdata", 64'(s.tdata), 64'(exp_rgb));
      chk("tuser", 64'(s.tuser), 64'(b == 0));
      chk("tlast", 64'(s.tlast), 64'(px == XS - 1));
      if (b == stall_beat) begin
        d = s.tdata; u = s.tuser; l = s.tlast;
        for (int i = 0; i < 10; i++) begin
          @(negedge aclk);
          chk("stall_hold", 64'({s.tvalid, s.tuser, s.tlast, s.tdata}), 64'({1'b1, u, l, d}));
        end
        s.tready = 1'b1;
      end
      #1;
      chk("frame_done", 64'(frame_done), 64'(b == NPIX - 1));
      if (b == 0 && !keep_run) begin
        run = 1'b0;
        apply(rand_cfg());
      end
      acc = cyc + 1;
      last_acc = acc;
      if (b == stall_beat - 1) begin
        @(posedge aclk);
        #1 s.tready = 1'b0;
      end
    end
    if (!keep_run) begin
      repeat (4) @(negedge aclk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_tvalid", 64'(s.tvalid), 64'd0);
    end
  endtask

  initial begin
    bit   ok;
    cfg_t c;
    tab[0] = '{c: '{md: 0, mi: 50, jre: 0, jim: 0, ore: 640,  oim: 0, sre: 0, sim: 0}, rgb0: 24'h010305, lat0: 3};
    tab[1] = '{c: '{md: 0, mi: 50, jre: 0, jim: 0, ore: 0,    oim: 0, sre: 0, sim: 0}, rgb0: 24'h000000, lat0: 52};
    tab[2] = '{c: '{md: 0, mi: 0,  jre: 0, jim: 0, ore: 0,    oim: 0, sre: 0, sim: 0}, rgb0: 24'h000000, lat0: 3};
    tab[3] = '{c: '{md: 1, mi: 10, jre: 0, jim: 0, ore: 768,  oim: 0, sre: 0, sim: 0}, rgb0: 24'h000000, lat0: 2};
    tab[4] = '{c: '{md: 0, mi: 50, jre: 0, jim: 0, ore: 512,  oim: 0, sre: 0, sim: 0}, rgb0: 24'h02060a, lat0: 4};
    tab[5] = '{c: '{md: 0, mi: 20, jre: 0, jim: 0, ore: -512, oim: 0, sre: 0, sim: 0}, rgb0: 24'h000000, lat0: 22};

    s.tready = 1'b1;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_tvalid", 64'(s.tvalid), 64'd0);
    chk("reset_tdata", 64'(s.tdata), 64'd0);
    chk("reset_sideband", 64'({s.tuser, s.tlast, frame_done}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame(tab[i].c, -1, 1'b0);
      chk("tab_rgb0", 64'(rgb0), 64'(tab[i].rgb0));
      chk("tab_lat0", 64'(lat0), 64'(tab[i].lat0));
    end

    run_frame(tab[0].c, 2, 1'b0);
    run_frame(tab[4].c, 0, 1'b0);

    // Back-to-back frames while run stays high.
    run_frame(tab[0].c, -1, 1'b1);
    wait_valid(600, ok);
    chk("b2b_valid", 64'(ok), 64'd1);
    chk("b2b_tuser", 64'(s.tuser), 64'd1);
    chk("b2b_tdata", 64'(s.tdata), 64'h010305);
    chk("b2b_latency", 64'(cyc - last_acc), 64'd3);
    run = 1'b0;
    for (int i = 0; i < 2000 && busy; i++) @(negedge aclk);
    chk("drain_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 25; i++) begin
      c = rand_cfg();
      run_frame(c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NPIX - 1)) : -1, 1'b0);
    end

    // Async reset in the middle of a long iteration.
    @(negedge aclk);
    apply(tab[1].c);
    run = 1'b1;
    repeat (20) @(negedge aclk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("async_reset_tvalid", 64'(s.tvalid), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_frame_done", 64'(frame_done), 64'd0);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    run_frame(tab[0].c, -1, 1'b0);
    chk("post_reset_rgb0", 64'(rgb0), 64'h010305);
    chk("post_reset_lat0", 64'(lat0), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
